// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: one ALU shared across fetch/decode/execute/mem/writeback.
// Outputs decode combinationally from state and inputs; FETCH, MEMRD and MEMWR stall on mem_ready.
module mips_multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               ir_write,
  output logic               mem_write,
  output logic               i_or_d,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [2:0]         alu_op_sel,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_e     state_q, state_d;
  logic       funct_ok;
  logic [2:0] funct_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    funct_ok = 1'b1;
    funct_op = ALU_ADD;
    case (funct)
      FN_ADD:  funct_op = ALU_ADD;
      FN_SUB:  funct_op = ALU_SUB;
      FN_AND:  funct_op = ALU_AND;
      FN_OR:   funct_op = ALU_OR;
      FN_SLT:  funct_op = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_op_sel = ALU_ADD;
    illegal_op = 1'b0;

    case (state_q)
      S_FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Speculatively form the branch target while the opcode is decoded.
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          OP_RTYPE: begin
            if (funct_ok) begin
              state_d = S_EXECUTE;
            end else begin
              state_d    = S_FETCH;
              illegal_op = 1'b1;
            end
          end
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        i_or_d = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        alu_src_a  = 1'b1;
        alu_op_sel = funct_op;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op_sel = ALU_SUB;
        pc_src     = 2'b01;
        pc_en      = zero;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = 2'b10;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // State is already FETCH under reset; only the strobes need masking.
    if (rst) begin
      pc_en      = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign state_dbg = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-cycle expected output vectors are queued by the stimulus
// and popped by an independent negedge monitor that compares them with the DUT outputs.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b1;
  logic       rst = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_en, ir_write, mem_write, i_or_d, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_op_sel;
  logic       illegal_op;
  logic [3:0] state_dbg;

  mips_multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .ir_write(ir_write), .mem_write(mem_write), .i_or_d(i_or_d),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op_sel(alu_op_sel), .illegal_op(illegal_op),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Vector layout: state | pc_en ir_write mem_write reg_write illegal_op |
  //                i_or_d reg_dst mem_to_reg alu_src_a | alu_src_b | pc_src | alu_op_sel
  logic [19:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          step_no = 0;

  always @(negedge clk) begin
    logic [19:0] exp_v, act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {state_dbg, pc_en, ir_write, mem_write, reg_write, illegal_op,
               i_or_d, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_op_sel};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL step%0d outputs: actual=%05h required=%05h", step_no, act_v, exp_v);
      end
      step_no++;
    end
  end

  task automatic e(input logic [3:0] st, input logic [4:0] strb, input logic [3:0] flg,
                   input logic [1:0] srcb, input logic [1:0] pcs, input logic [2:0] op);
    exp_q.push_back({st, strb, flg, srcb, pcs, op});
    @(posedge clk);
    #1;
  endtask

  task automatic t_reset();
    rst = 1'b1; mem_ready = 1'b1;
    e(4'd0, 5'b00000, 4'b0000, 2'b01, 2'b00, 3'b010);
  endtask
  task automatic t_fetch(input logic mr);
    mem_ready = mr;
    e(4'd0, {mr, mr, 3'b000}, 4'b0000, 2'b01, 2'b00, 3'b010);
  endtask
  task automatic t_decode(input logic ill);
    mem_ready = 1'b0;
    e(4'd1, {4'b0000, ill}, 4'b0000, 2'b11, 2'b00, 3'b010);
  endtask
  task automatic t_memadr();
    e(4'd2, 5'b00000, 4'b0001, 2'b10, 2'b00, 3'b010);
  endtask
  task automatic t_memrd(input logic mr);
    mem_ready = mr;
    e(4'd3, 5'b00000, 4'b1000, 2'b00, 2'b00, 3'b010);
  endtask
  task automatic t_memwb();
    e(4'd4, 5'b00010, 4'b0010, 2'b00, 2'b00, 3'b010);
  endtask
  task automatic t_memwr(input logic mr);
    mem_ready = mr;
    e(4'd5, 5'b00100, 4'b1000, 2'b00, 2'b00, 3'b010);
  endtask
  task automatic t_exec(input logic [2:0] op);
    zero = 1'b1;
    e(4'd6, 5'b00000, 4'b0001, 2'b00, 2'b00, op);
  endtask
  task automatic t_aluwb();
    e(4'd7, 5'b00010, 4'b0100, 2'b00, 2'b00, 3'b010);
  endtask
  task automatic t_branch(input logic z);
    zero = z;
    e(4'd8, {z, 4'b0000}, 4'b0001, 2'b00, 2'b01, 3'b110);
  endtask
  task automatic t_addiex();
    e(4'd9, 5'b00000, 4'b0001, 2'b10, 2'b00, 3'b010);
  endtask
  task automatic t_addiwb();
    e(4'd10, 5'b00010, 4'b0000, 2'b00, 2'b00, 3'b010);
  endtask
  task automatic t_jump();
    e(4'd11, 5'b10000, 4'b0000, 2'b00, 2'b10, 3'b010);
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [2:0] op);
    opcode = 6'b000000; funct = fn;
    t_fetch(1'b1); t_decode(1'b0); t_exec(op); t_aluwb();
  endtask

  initial begin
    #1;
    t_reset();
    rst = 1'b0;

    rtype(6'b100000, 3'b010);
    rtype(6'b100010, 3'b110);
    rtype(6'b100100, 3'b000);
    rtype(6'b100101, 3'b001);
    rtype(6'b101010, 3'b111);

    opcode = 6'b100011; funct = 6'b000000;
    t_fetch(1'b1); t_decode(1'b0); t_memadr();
    t_memrd(1'b0); t_memrd(1'b0); t_memrd(1'b1); t_memwb();

    opcode = 6'b101011;
    t_fetch(1'b1); t_decode(1'b0); t_memadr(); t_memwr(1'b1);

    opcode = 6'b001000;
    t_fetch(1'b1); t_decode(1'b0); t_addiex(); t_addiwb();

    opcode = 6'b000100;
    t_fetch(1'b1); t_decode(1'b0); t_branch(1'b1);
    t_fetch(1'b1); t_decode(1'b0); t_branch(1'b0);

    opcode = 6'b000010;
    t_fetch(1'b0); t_fetch(1'b1); t_decode(1'b0); t_jump();

    opcode = 6'b111111;
    t_fetch(1'b1); t_decode(1'b1);
    opcode = 6'b000000; funct = 6'b000111;
    t_fetch(1'b1); t_decode(1'b1);

    // Abandon a stalled store with an asynchronous reset mid-cycle.
    opcode = 6'b101011; funct = 6'b000000;
    t_fetch(1'b1); t_decode(1'b0); t_memadr(); t_memwr(1'b0);
    t_reset();
    rst = 1'b0;
    opcode = 6'b000010;
    t_fetch(1'b1); t_decode(1'b0); t_jump();
    t_fetch(1'b1);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
